ysyx_22041211_pc_gen: RTL and testbench

Program-counter generator that holds the architectural PC and issues it to the instruction-fetch stage.
- Drives the current PC (pc_old) to the branch-target adder and receives the computed target back (pcBranch).
- Selects the next PC on instruction completion: taken branch target, or sequential PC+4.
- Sits between the branch-target adder, the fetch unit (valid/ready handshake) and the execute/writeback completion signal.

---
 rtl/ysyx_22041211_pc_gen.sv | 110 +++++++++++
 tb/tb_ysyx_22041211_pc_gen.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041211_pc_gen.sv
// Program-counter generator: holds the architectural PC, issues it to fetch over a
// valid/ready handshake and advances it on instruction completion.
// Optional target alignment check: define YSYX_22041211_PC_ALIGN_CHECK_EN.
module ysyx_22041211_pc_gen #(
  parameter int unsigned         DATA_LEN  = 32,
  parameter logic [DATA_LEN-1:0] RESET_VAL = DATA_LEN'(32'h8000_0000)
) (
  input  logic                clk,
  input  logic                rst,
  output logic [DATA_LEN-1:0] pc_old,
  input  logic [DATA_LEN-1:0] pcBranch,
  input  logic                branch_taken,
  input  logic                inst_done,
  output logic                if_valid,
  input  logic                if_ready,
  output logic [63:0]         inst_cnt,
  output logic                misalign_err
);

`ifdef YSYX_22041211_PC_ALIGN_CHECK_EN
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_e;
`else
  typedef enum logic {
    S_FETCH = 1'b0,
    S_EXEC  = 1'b1
  } state_e;
`endif

  state_e              state_q, state_d;
  logic [DATA_LEN-1:0] pc_q, pc_d;
  logic [63:0]         cnt_q, cnt_d;
`ifdef YSYX_22041211_PC_ALIGN_CHECK_EN
  logic                misalign_q, misalign_d;
`endif

  // NOTE: every signal assigned here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
`ifdef YSYX_22041211_PC_ALIGN_CHECK_EN
    misalign_d = 1'b0;
`endif
    unique case (state_q)
      // if_valid is high throughout FETCH outside reset, and reset overrides the
      // register update anyway, so if_ready alone marks the transfer.
      S_FETCH: begin
        if (if_ready) state_d = S_EXEC;
      end
      S_EXEC: begin
        if (inst_done) begin
          cnt_d   = cnt_q + 64'd1;
          state_d = S_FETCH;
`ifdef YSYX_22041211_PC_ALIGN_CHECK_EN
          if (branch_taken && (pcBranch[1:0] != 2'b00)) begin
            misalign_d = 1'b1;
            state_d    = S_HALT;
          end else begin
            pc_d = branch_taken ? pcBranch : pc_q + DATA_LEN'(4);
          end
`else
          pc_d = branch_taken ? pcBranch : pc_q + DATA_LEN'(4);
`endif
        end
      end
`ifdef YSYX_22041211_PC_ALIGN_CHECK_EN
      S_HALT: begin
        state_d = S_HALT;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_VAL;
      cnt_q   <= '0;
`ifdef YSYX_22041211_PC_ALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
`ifdef YSYX_22041211_PC_ALIGN_CHECK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  // rst -> if_valid is the only combinational input-to-output path.
  assign if_valid = (state_q == S_FETCH) && !rst;
  assign pc_old   = pc_q;
  assign inst_cnt = cnt_q;
`ifdef YSYX_22041211_PC_ALIGN_CHECK_EN
  assign misalign_err = misalign_q;
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_22041211_pc_gen.sv
// Scoreboard bench for ysyx_22041211_pc_gen: the stimulus side keeps an
// architectural PC/count model and queues the expected state of each fetch.
module tb_ysyx_22041211_pc_gen;
  localparam logic [31:0] RST_VAL = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_old;
  logic [31:0] pcBranch;
  logic        branch_taken;
  logic        inst_done;
  logic        if_valid;
  logic        if_ready;
  logic [63:0] inst_cnt;
  logic        misalign_err;

  ysyx_22041211_pc_gen #(.DATA_LEN(32), .RESET_VAL(RST_VAL)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_old       (pc_old),
    .pcBranch     (pcBranch),
    .branch_taken (branch_taken),
    .inst_done    (inst_done),
    .if_valid     (if_valid),
    .if_ready     (if_ready),
    .inst_cnt     (inst_cnt),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [63:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_pc;
  logic [63:0] m_cnt;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expectation per accepted fetch; checks PC stability under stall.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && if_valid) begin
      if (if_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_fetch", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check("fetch_pc", {32'd0, pc_old}, {32'd0, e.pc});
          check("fetch_cnt", inst_cnt, e.cnt);
`ifndef YSYX_22041211_PC_ALIGN_CHECK_EN
          check("misalign_zero", {63'd0, misalign_err}, 64'd0);
`endif
        end
      end else begin
        check("stall_pc", {32'd0, pc_old}, {32'd0, m_pc});
      end
    end
  end

  task automatic model_reset();
    sb_q.delete();
    m_pc  = RST_VAL;
    m_cnt = '0;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1; if_ready = 1'b0; inst_done = 1'b0; branch_taken = 1'b0;
    model_reset();
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("rst_if_valid", {63'd0, if_valid}, 64'd0);
      tick();
    end
    rst = 1'b0;
    sb_q.push_back('{pc: m_pc, cnt: m_cnt});
    @(negedge clk);
    check("post_rst_pc", {32'd0, pc_old}, {32'd0, RST_VAL});
    check("post_rst_cnt", inst_cnt, 64'd0);
    check("post_rst_if_valid", {63'd0, if_valid}, 64'd1);
    tick();
  endtask

  // Stall for 'stall' cycles (optionally poking inst_done/branch_taken, which FETCH
  // must ignore), then hold if_ready until the request is accepted.
  task automatic fetch(input int stall, input bit inject);
    bit got;
    for (int i = 0; i < stall; i++) begin
      if_ready     = 1'b0;
      inst_done    = inject ? 1'($urandom_range(0, 1)) : 1'b0;
      branch_taken = inject ? 1'($urandom_range(0, 1)) : 1'b0;
      pcBranch     = $urandom;
      tick();
    end
    inst_done = 1'b0; branch_taken = 1'b0; if_ready = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 16 && !got; n++) begin
      @(negedge clk);
      got = if_valid;
      tick();
    end
    if_ready = 1'b0;
    if (!got) check("fetch_timeout", 64'd1, 64'd0);
  endtask

  // Wait 'delay' EXEC cycles with distractors, then signal one completion.
  task automatic complete(input int delay, input logic taken, input logic [31:0] target);
    for (int i = 0; i < delay; i++) begin
      inst_done    = 1'b0;
      branch_taken = 1'($urandom_range(0, 1));
      pcBranch     = $urandom;
      if_ready     = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("exec_if_valid", {63'd0, if_valid}, 64'd0);
      tick();
    end
    if_ready = 1'b0;
    inst_done = 1'b1; branch_taken = taken; pcBranch = target;
    m_cnt = m_cnt + 64'd1;
    m_pc  = taken ? target : m_pc + 32'd4;
    sb_q.push_back('{pc: m_pc, cnt: m_cnt});
    tick();
    inst_done = 1'b0; branch_taken = 1'b0;
    @(negedge clk);
    check("done_if_valid", {63'd0, if_valid}, 64'd1);
    check("done_pc", {32'd0, pc_old}, {32'd0, m_pc});
    check("done_cnt", inst_cnt, m_cnt);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; if_ready = 1'b0; inst_done = 1'b0; branch_taken = 1'b0; pcBranch = '0;
    model_reset();

    do_reset(2);

    // Back-pressure, then three sequential rounds.
    fetch(5, 1'b0);
    complete(1, 1'b0, 32'd0);
    fetch(0, 1'b0);
    complete(0, 1'b0, 32'd0);
    fetch(1, 1'b0);
    complete(2, 1'b0, 32'd0);
    check("seq_pc", {32'd0, pc_old}, 64'h8000_000C);
    check("seq_cnt", inst_cnt, 64'd3);

    // Taken branch, then FETCH-state completion pulses must be ignored.
    fetch(0, 1'b0);
    complete(0, 1'b0, 32'd0);
    fetch(0, 1'b0);
    complete(1, 1'b1, 32'h8000_0100);
    check("taken_pc", {32'd0, pc_old}, 64'h8000_0100);
    fetch(4, 1'b1);

    // Wrap: branch to the top word, then one sequential completion.
    complete(0, 1'b1, 32'hFFFF_FFFC);
    fetch(0, 1'b0);
    complete(0, 1'b0, 32'd0);
    check("wrap_pc", {32'd0, pc_old}, 64'd0);

    // Reset coinciding with a completion in EXEC: reset wins.
    fetch(0, 1'b0);
    inst_done = 1'b1; branch_taken = 1'b0; rst = 1'b1;
    tick();
    inst_done = 1'b0;
    @(negedge clk);
    check("rst_done_pc", {32'd0, pc_old}, {32'd0, RST_VAL});
    check("rst_done_cnt", inst_cnt, 64'd0);
    check("rst_done_if_valid", {63'd0, if_valid}, 64'd0);
    do_reset(1);

    // Randomised rounds against the model.
    for (int r = 0; r < 40; r++) begin
      logic        tk;
      logic [31:0] tgt;
      tk  = 1'($urandom_range(0, 1));
      tgt = $urandom & 32'hFFFF_FFFC;
      fetch($urandom_range(0, 3), 1'b1);
      complete($urandom_range(0, 3), tk, tgt);
    end

    // Misaligned taken target.
    fetch(0, 1'b0);
`ifdef YSYX_22041211_PC_ALIGN_CHECK_EN
    begin
      logic [31:0] held_pc;
      held_pc = m_pc;
      inst_done = 1'b1; branch_taken = 1'b1; pcBranch = 32'h8000_0102;
      m_cnt = m_cnt + 64'd1;
      tick();
      inst_done = 1'b0; branch_taken = 1'b0; if_ready = 1'b1;
      @(negedge clk);
      check("misalign_pulse", {63'd0, misalign_err}, 64'd1);
      check("misalign_pc", {32'd0, pc_old}, {32'd0, held_pc});
      check("misalign_cnt", inst_cnt, m_cnt);
      check("halt_if_valid", {63'd0, if_valid}, 64'd0);
      for (int i = 0; i < 4; i++) begin
        tick();
        inst_done = 1'($urandom_range(0, 1)); pcBranch = $urandom;
        @(negedge clk);
        check("misalign_one_cycle", {63'd0, misalign_err}, 64'd0);
        check("halt_hold_valid", {63'd0, if_valid}, 64'd0);
        check("halt_hold_pc", {32'd0, pc_old}, {32'd0, held_pc});
      end
      tick();
      inst_done = 1'b0;
    end
`else
    complete(0, 1'b1, 32'h8000_0102);
    check("misalign_loaded_pc", {32'd0, pc_old}, 64'h8000_0102);
    check("misalign_err_off", {63'd0, misalign_err}, 64'd0);
    fetch(0, 1'b0);
`endif

    do_reset(2);
    check("sb_drained", 64'(sb_q.size()), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
